oclib_csr_regfile: RTL
======================

OCLIB_CSR_REGFILE -- requirements
Module: oclib_csr_regfile

Interface
REQ-001 Parameter NumRegs, default 8, SHALL set the number of 32-bit registers; legal range 1..64.
REQ-002 Parameter AnswerToBlock, default oclib_pkg::BcBlockIdAny, SHALL set the matched csr.toblock; the Any value matches all blocks.
REQ-003 Parameter AnswerToSpace, default oclib_pkg::BcSpaceIdAny, SHALL set the matched csr.space; the Any value matches all spaces.
REQ-004 Parameter InitValues, default all-zero, SHALL be a NumRegs x 32-bit array of reset values.
REQ-005 Parameter ReadOnlyMask, default 0, SHALL be a NumRegs-bit mask; a set bit makes that register read-only, returning regIn.
REQ-006 Port clock, input, 1 bit, SHALL be the single clock.
REQ-007 Port reset, input, 1 bit, SHALL be the reset: asynchronous and active-low.
REQ-008 Port csr, input, oclib_pkg::csr_32_s, SHALL be the request: toblock, space, address, wdata, read, write.
REQ-009 Port csrFb, output, oclib_pkg::csr_32_fb_s, SHALL be the response: rdata, ready, error.
REQ-010 Port regOut, output, NumRegs x 32, SHALL carry the current register contents.
REQ-011 Port regIn, input, NumRegs x 32, SHALL supply the read data for read-only registers.
REQ-012 Port writePulse, output, NumRegs bits, SHALL pulse high for one cycle on the cycle a register is written.

Function
REQ-013 The FSM SHALL have exactly three states: Idle, Respond and WaitRelease.
REQ-014 Idle->Respond SHALL occur when (read|write) is high and both toblock and space match; on a mismatch the FSM SHALL stay in Idle and drive no response.
REQ-015 Index SHALL be address[2 +: clog2(NumRegs)]; address[1:0] SHALL be ignored.
REQ-016 An index >= NumRegs, or any nonzero address bit above the index field, SHALL set error.
REQ-017 Read and write both high SHALL set error and SHALL cause no write.
REQ-018 On the Idle->Respond edge, a legal write to a writable register SHALL update it and pulse writePulse[index].
REQ-019 A write to a read-only register SHALL complete with ready=1 and error=0, and SHALL cause no update and no pulse.
REQ-020 In Respond, ready SHALL be 1 for exactly one cycle; rdata and error SHALL be valid in that cycle; rdata SHALL be 0 on writes and errors.
REQ-021 Latency: for a request first high at edge N, ready SHALL be high during cycle N+1.
REQ-022 Respond SHALL always go to WaitRelease, and WaitRelease->Idle SHALL occur only when read and write are both low; this makes a held request execute once.
REQ-023 Outside Respond, csrFb SHALL be all-zero.
REQ-024 A request that drops in the same cycle as ready SHALL be legal.

Reset
REQ-025 Asserting reset (low) at any time, including mid-transaction, SHALL immediately force state=Idle, csrFb=0, writePulse=0 and regOut=InitValues.
REQ-026 On reset release, the first request SHALL be accepted no earlier than the first clock edge after release.

Configuration
REQ-027 With macro OCLIB_CSR_REGFILE_W1C_EN defined, parameter W1cMask (NumRegs bits) and input setIn (NumRegs x 32) SHALL exist.
REQ-028 With OCLIB_CSR_REGFILE_W1C_EN defined, a W1C register SHALL compute next = (cur & ~wdata_if_written) | setIn every cycle, with set winning over a simultaneous clear.
REQ-029 With OCLIB_CSR_REGFILE_W1C_EN undefined, W1cMask and setIn SHALL be absent and all writable registers SHALL be plain read/write.

Structure
REQ-030 oclib_pkg SHALL hold csr_32_s, csr_32_fb_s, BcBlockIdAny and BcSpaceIdAny; no new package types SHALL be added.
REQ-031 The block SHALL be a single module with no sub-modules; it sits directly downstream of one oclib_csr_adapter space output.

Verification
REQ-032 Write 0xDEADBEEF to address 0x8 with NumRegs=8 -> ready at N+1 with error=0; regOut[2]=0xDEADBEEF; writePulse[2] pulses once.
REQ-033 Hold read of address 0x8 for 5 cycles -> exactly one ready pulse with rdata=0xDEADBEEF, then Idle after the read drops.
REQ-034 Read address 0x20 with NumRegs=8 -> ready=1, error=1, rdata=0.
REQ-035 Request with toblock=5 against AnswerToBlock=3 -> no ready for 10 cycles; state stays Idle.
REQ-036 Assert reset while in WaitRelease after a write of 0x1 to reg 0 -> regOut[0]=InitValues[0] and csrFb=0 immediately.
REQ-037 With W1C enabled, reg 1 = 0xF0, write 0x30 while setIn[1]=0x01 -> regOut[1]=0xC1.

Source files
------------

// File: rtl/oclib_pkg.sv
// Shared CSR bus types and broadcast identifiers used by the oclib register blocks.
package oclib_pkg;

  localparam logic [7:0] BcBlockIdAny = 8'hFF;
  localparam logic [7:0] BcSpaceIdAny = 8'hFF;

  typedef struct packed {
    logic [7:0]  toblock;
    logic [7:0]  space;
    logic [31:0] address;
    logic [31:0] wdata;
    logic        read;
    logic        write;
  } csr_32_s;

  typedef struct packed {
    logic [31:0] rdata;
    logic        ready;
    logic        error;
  } csr_32_fb_s;

endpackage

// File: rtl/oclib_csr_regfile.sv
// CSR-mapped register file: NumRegs x 32-bit registers with read-only and write-pulse support.
// Optional write-1-to-clear registers with a set input: define OCLIB_CSR_REGFILE_W1C_EN.
module oclib_csr_regfile
  import oclib_pkg::*;
#(
  parameter int                         NumRegs       = 8,
  parameter logic [7:0]                 AnswerToBlock = BcBlockIdAny,
  parameter logic [7:0]                 AnswerToSpace = BcSpaceIdAny,
  parameter logic [NumRegs-1:0][31:0]   InitValues    = '0,
  parameter logic [NumRegs-1:0]         ReadOnlyMask  = '0
`ifdef OCLIB_CSR_REGFILE_W1C_EN
  ,
  parameter logic [NumRegs-1:0]         W1cMask       = '0
`endif
) (
  input  logic                       clock,
  input  logic                       reset,
  input  csr_32_s                    csr,
  output csr_32_fb_s                 csrFb,
  output logic [NumRegs-1:0][31:0]   regOut,
  input  logic [NumRegs-1:0][31:0]   regIn,
`ifdef OCLIB_CSR_REGFILE_W1C_EN
  input  logic [NumRegs-1:0][31:0]   setIn,
`endif
  output logic [NumRegs-1:0]         writePulse
);

  localparam int IdxW = (NumRegs > 1) ? $clog2(NumRegs) : 1;

  typedef enum logic [1:0] {
    Idle,
    Respond,
    WaitRelease
  } state_e;

  state_e                     state;
  state_e                     stateNext;
  logic [NumRegs-1:0][31:0]   regQ;
  logic [31:0]                rdataQ;
  logic                       errQ;
  logic [IdxW-1:0]            idx;
  logic                       match;
  logic                       accept;
  logic                       decErr;
  logic                       doWrite;
  logic [NumRegs-1:0]         wrHit;
  logic [31:0]                rdSel;

  assign idx    = csr.address[2 +: IdxW];
  assign match  = ((AnswerToBlock == BcBlockIdAny) || (csr.toblock == AnswerToBlock)) &&
                  ((AnswerToSpace == BcSpaceIdAny) || (csr.space == AnswerToSpace));
  assign accept = (state == Idle) && (csr.read || csr.write) && match;
  assign decErr = (|(csr.address >> (2 + IdxW))) ||
                  ({1'b0, idx} >= (IdxW + 1)'(NumRegs)) ||
                  (csr.read && csr.write);

  always_comb begin
    rdSel   = '0;
    wrHit   = '0;
    doWrite = accept && csr.write && !csr.read && !decErr;
    for (int unsigned i = 0; i < NumRegs; i++) begin
      if (idx == IdxW'(i)) begin
        rdSel    = ReadOnlyMask[i] ? regIn[i] : regQ[i];
        wrHit[i] = doWrite && !ReadOnlyMask[i];
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= Idle;
    else        state <= stateNext;
  end

  // Respond always passes through WaitRelease so a held request executes only once.
  always_comb begin
    stateNext = state;
    unique case (state)
      Idle:        if (accept) stateNext = Respond;
      Respond:     stateNext = WaitRelease;
      WaitRelease: if (!csr.read && !csr.write) stateNext = Idle;
      default:     stateNext = Idle;
    endcase
  end

  always_comb begin
    csrFb = '0;
    if (state == Respond) begin
      csrFb.ready = 1'b1;
      csrFb.rdata = rdataQ;
      csrFb.error = errQ;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      regQ       <= InitValues;
      writePulse <= '0;
      rdataQ     <= '0;
      errQ       <= 1'b0;
    end else begin
      writePulse <= wrHit;
      for (int unsigned i = 0; i < NumRegs; i++) begin
`ifdef OCLIB_CSR_REGFILE_W1C_EN
        if (W1cMask[i])
          regQ[i] <= (regQ[i] & ~(wrHit[i] ? csr.wdata : '0)) | setIn[i];
        else
`endif
        if (wrHit[i]) regQ[i] <= csr.wdata;
      end
      if (accept) begin
        rdataQ <= (csr.read && !decErr) ? rdSel : '0;
        errQ   <= decErr;
      end
    end
  end

  assign regOut = regQ;

endmodule
